// File: rtl/reorder_buffer_pkg.sv
// Shared types and constants for the reorder buffer slice.
// These mirror the core's global defines for data, register and ROB sizes.
package reorder_buffer_pkg;

    localparam int DEFAULT_ROB_SIZE     = 16;
    localparam int DEFAULT_ROB_ID_WIDTH = 5;
    localparam int DATA_WIDTH           = 32;
    localparam int REG_POS_WIDTH        = 5;

    typedef logic [DATA_WIDTH-1:0]    data_t;
    typedef logic [REG_POS_WIDTH-1:0] reg_pos_t;

    localparam reg_pos_t ZERO_REG = '0;

endpackage

// File: rtl/reorder_buffer.sv
// Circular in-order commit buffer: allocates per dispatch, captures CDB results,
// retires the head into the register file and flushes on a mispredicted jump.
module reorder_buffer
    import reorder_buffer_pkg::*;
#(
    parameter int ROB_SIZE     = DEFAULT_ROB_SIZE,
    parameter int ROB_ID_WIDTH = DEFAULT_ROB_ID_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable_sign_from_cmd,
    input  logic [4:0]              rd_from_cmd,
    input  logic                    is_jump_from_cmd,
    input  logic [31:0]             predicted_pc_from_cmd,
    output logic [ROB_ID_WIDTH-1:0] rob_id_to_cmd,
    output logic                    full_to_cmd,
    input  logic [ROB_ID_WIDTH-1:0] query_id1_from_cmd,
    input  logic [ROB_ID_WIDTH-1:0] query_id2_from_cmd,
    output logic                    query_ready1_to_cmd,
    output logic                    query_ready2_to_cmd,
    output logic [31:0]             query_V1_to_cmd,
    output logic [31:0]             query_V2_to_cmd,
    input  logic                    valid_from_cdb,
    input  logic [ROB_ID_WIDTH-1:0] rob_id_from_cdb,
    input  logic [31:0]             V_from_cdb,
    input  logic [31:0]             real_pc_from_cdb,
    output logic                    commit_sign_to_reg,
    output logic [31:0]             V_to_reg,
    output logic [ROB_ID_WIDTH-1:0] Q_to_reg,
    output logic [4:0]              rd_to_reg,
    output logic                    rollback_sign,
    output logic [31:0]             rollback_pc_to_if
);

    localparam int IDX_W = $clog2(ROB_SIZE);

    typedef logic [ROB_ID_WIDTH-1:0] rob_id_t;
    typedef logic [IDX_W-1:0]        idx_t;

    localparam rob_id_t INVALID_ROB = rob_id_t'(ROB_SIZE);

    logic     ent_busy    [ROB_SIZE];
    logic     ent_ready   [ROB_SIZE];
    reg_pos_t ent_rd      [ROB_SIZE];
    data_t    ent_value   [ROB_SIZE];
    logic     ent_is_jump [ROB_SIZE];
    data_t    ent_pred_pc [ROB_SIZE];
    data_t    ent_real_pc [ROB_SIZE];

    idx_t    head, tail;
    rob_id_t count;

    logic commit_now, mispredict, alloc, cdb_fwd, cdb_hit;
    idx_t cdb_idx, q1_idx, q2_idx;

    // IDs at or above ROB_SIZE (INVALID_ROB) never name a real entry.
    function automatic logic id_in_range(input rob_id_t id);
        return id[ROB_ID_WIDTH-1:IDX_W] == '0;
    endfunction

    assign rob_id_to_cmd = rob_id_t'(tail);
    assign full_to_cmd   = (count == INVALID_ROB) || rollback_sign;

    assign cdb_idx = rob_id_from_cdb[IDX_W-1:0];
    assign q1_idx  = query_id1_from_cmd[IDX_W-1:0];
    assign q2_idx  = query_id2_from_cmd[IDX_W-1:0];

    assign commit_now = ent_busy[head] && ent_ready[head] && !rollback_sign;
    assign mispredict = commit_now && ent_is_jump[head] && (ent_real_pc[head] != ent_pred_pc[head]);
    assign alloc      = enable_sign_from_cmd && !full_to_cmd;
    assign cdb_fwd    = valid_from_cdb && !rollback_sign;
    assign cdb_hit    = cdb_fwd && id_in_range(rob_id_from_cdb) && ent_busy[cdb_idx];

    // A same-cycle CDB broadcast wins over the stored entry so dispatch never misses a result.
    assign query_ready1_to_cmd = id_in_range(query_id1_from_cmd) &&
        ((cdb_fwd && rob_id_from_cdb == query_id1_from_cmd) || (ent_busy[q1_idx] && ent_ready[q1_idx]));
    assign query_V1_to_cmd = (cdb_fwd && rob_id_from_cdb == query_id1_from_cmd) ? V_from_cdb : ent_value[q1_idx];
    assign query_ready2_to_cmd = id_in_range(query_id2_from_cmd) &&
        ((cdb_fwd && rob_id_from_cdb == query_id2_from_cmd) || (ent_busy[q2_idx] && ent_ready[q2_idx]));
    assign query_V2_to_cmd = (cdb_fwd && rob_id_from_cdb == query_id2_from_cmd) ? V_from_cdb : ent_value[q2_idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            head               <= '0;
            tail               <= '0;
            count              <= '0;
            commit_sign_to_reg <= 1'b0;
            rollback_sign      <= 1'b0;
            V_to_reg           <= '0;
            Q_to_reg           <= INVALID_ROB;
            rd_to_reg          <= ZERO_REG;
            rollback_pc_to_if  <= '0;
            for (int unsigned i = 0; i < ROB_SIZE; i++) begin
                ent_busy[i]  <= 1'b0;
                ent_ready[i] <= 1'b0;
            end
        end else begin
            commit_sign_to_reg <= commit_now;
            rollback_sign      <= mispredict;
            if (commit_now) begin
                V_to_reg  <= ent_value[head];
                Q_to_reg  <= rob_id_t'(head);
                rd_to_reg <= ent_rd[head];
            end
            // The mispredicted jump still retires its link value; everything younger is dropped.
            if (mispredict) begin
                rollback_pc_to_if <= ent_real_pc[head];
                head              <= '0;
                tail              <= '0;
                count             <= '0;
                for (int unsigned i = 0; i < ROB_SIZE; i++) begin
                    ent_busy[i]  <= 1'b0;
                    ent_ready[i] <= 1'b0;
                end
            end else begin
                if (alloc) begin
                    ent_busy[tail]    <= 1'b1;
                    ent_ready[tail]   <= 1'b0;
                    ent_rd[tail]      <= rd_from_cmd;
                    ent_is_jump[tail] <= is_jump_from_cmd;
                    ent_pred_pc[tail] <= predicted_pc_from_cmd;
                    tail              <= tail + 1'b1;
                end
                if (cdb_hit) begin
                    ent_ready[cdb_idx]   <= 1'b1;
                    ent_value[cdb_idx]   <= V_from_cdb;
                    ent_real_pc[cdb_idx] <= real_pc_from_cdb;
                end
                if (commit_now) begin
                    ent_busy[head]  <= 1'b0;
                    ent_ready[head] <= 1'b0;
                    head            <= head + 1'b1;
                end
                count <= count + rob_id_t'(alloc) - rob_id_t'(commit_now);
            end
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed, table-driven bench for reorder_buffer with hand-computed expectations
// plus hand-written sequences for fill/wrap and mid-operation reset.
module tb_reorder_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable_sign_from_cmd;
    logic [4:0]  rd_from_cmd;
    logic        is_jump_from_cmd;
    logic [31:0] predicted_pc_from_cmd;
    logic [4:0]  rob_id_to_cmd;
    logic        full_to_cmd;
    logic [4:0]  query_id1_from_cmd, query_id2_from_cmd;
    logic        query_ready1_to_cmd, query_ready2_to_cmd;
    logic [31:0] query_V1_to_cmd, query_V2_to_cmd;
    logic        valid_from_cdb;
    logic [4:0]  rob_id_from_cdb;
    logic [31:0] V_from_cdb;
    logic [31:0] real_pc_from_cdb;
    logic        commit_sign_to_reg;
    logic [31:0] V_to_reg;
    logic [4:0]  Q_to_reg;
    logic [4:0]  rd_to_reg;
    logic        rollback_sign;
    logic [31:0] rollback_pc_to_if;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    reorder_buffer #(.ROB_SIZE(16), .ROB_ID_WIDTH(5)) dut (
        .clk(clk), .rst(rst),
        .enable_sign_from_cmd(enable_sign_from_cmd), .rd_from_cmd(rd_from_cmd),
        .is_jump_from_cmd(is_jump_from_cmd), .predicted_pc_from_cmd(predicted_pc_from_cmd),
        .rob_id_to_cmd(rob_id_to_cmd), .full_to_cmd(full_to_cmd),
        .query_id1_from_cmd(query_id1_from_cmd), .query_id2_from_cmd(query_id2_from_cmd),
        .query_ready1_to_cmd(query_ready1_to_cmd), .query_ready2_to_cmd(query_ready2_to_cmd),
        .query_V1_to_cmd(query_V1_to_cmd), .query_V2_to_cmd(query_V2_to_cmd),
        .valid_from_cdb(valid_from_cdb), .rob_id_from_cdb(rob_id_from_cdb),
        .V_from_cdb(V_from_cdb), .real_pc_from_cdb(real_pc_from_cdb),
        .commit_sign_to_reg(commit_sign_to_reg), .V_to_reg(V_to_reg), .Q_to_reg(Q_to_reg),
        .rd_to_reg(rd_to_reg), .rollback_sign(rollback_sign), .rollback_pc_to_if(rollback_pc_to_if)
    );

    typedef struct {
        logic [31:0] rst, en, rd, jmp, pred;
        logic [31:0] cv, cid, cval, crpc;
        logic [31:0] q1, q2;
        logic [31:0] e_tail, e_full, e_qr1, e_qv1, e_qr2, e_qv2;
        logic [31:0] e_cm, e_v, e_q, e_rd, e_rb, e_pc;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic idle();
        rst = 1'b0;
        enable_sign_from_cmd = 1'b0;
        rd_from_cmd = '0;
        is_jump_from_cmd = 1'b0;
        predicted_pc_from_cmd = '0;
        valid_from_cdb = 1'b0;
        rob_id_from_cdb = '0;
        V_from_cdb = '0;
        real_pc_from_cdb = '0;
        query_id1_from_cmd = 5'd16;
        query_id2_from_cmd = 5'd16;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        // rst en rd jmp pred | cv cid cval crpc | q1 q2 | tail full qr1 qv1 qr2 qv2 | cm V Q rd rb pc
        vecs.push_back(vec_t'{1,0,0,0,0,      0,0,0,0,            16,16, 0,0,0,0,0,0,          0,0,16,0,0,0});
        vecs.push_back(vec_t'{0,1,5,0,0,      0,0,0,0,            16,16, 0,0,0,0,0,0,          0,0,16,0,0,0});
        vecs.push_back(vec_t'{0,0,0,0,0,      1,0,'h1234,0,       0,1,   1,0,1,'h1234,0,0,     0,0,16,0,0,0});
        vecs.push_back(vec_t'{0,0,0,0,0,      0,0,0,0,            0,16,  1,0,1,'h1234,0,0,     1,'h1234,0,5,0,0});
        vecs.push_back(vec_t'{0,0,0,0,0,      0,0,0,0,            0,16,  1,0,0,0,0,0,          0,'h1234,0,5,0,0});
        vecs.push_back(vec_t'{1,0,0,0,0,      0,0,0,0,            16,16, 0,0,0,0,0,0,          0,0,16,0,0,0});
        vecs.push_back(vec_t'{0,1,7,0,0,      0,0,0,0,            16,16, 0,0,0,0,0,0,          0,0,16,0,0,0});
        vecs.push_back(vec_t'{0,1,8,0,0,      0,0,0,0,            16,16, 1,0,0,0,0,0,          0,0,16,0,0,0});
        vecs.push_back(vec_t'{0,0,0,0,0,      1,1,'h11,0,         1,0,   2,0,1,'h11,0,0,       0,0,16,0,0,0});
        vecs.push_back(vec_t'{0,0,0,0,0,      1,0,'h22,0,         1,0,   2,0,1,'h11,1,'h22,    0,0,16,0,0,0});
        vecs.push_back(vec_t'{0,0,0,0,0,      0,0,0,0,            0,1,   2,0,1,'h22,1,'h11,    1,'h22,0,7,0,0});
        vecs.push_back(vec_t'{0,0,0,0,0,      0,0,0,0,            1,0,   2,0,1,'h11,0,0,       1,'h11,1,8,0,0});
        vecs.push_back(vec_t'{0,0,0,0,0,      0,0,0,0,            16,16, 2,0,0,0,0,0,          0,'h11,1,8,0,0});
        vecs.push_back(vec_t'{0,1,1,1,'h100,  0,0,0,0,            16,16, 2,0,0,0,0,0,          0,'h11,1,8,0,0});
        vecs.push_back(vec_t'{0,0,0,0,0,      1,2,'h104,'h200,    2,16,  3,0,1,'h104,0,0,      0,'h11,1,8,0,0});
        vecs.push_back(vec_t'{0,0,0,0,0,      0,0,0,0,            2,16,  3,0,1,'h104,0,0,      1,'h104,2,1,1,'h200});
        vecs.push_back(vec_t'{0,1,9,0,0,      1,2,'h55,0,         16,16, 0,1,0,0,0,0,          0,'h104,2,1,0,'h200});
        vecs.push_back(vec_t'{0,0,0,0,0,      0,0,0,0,            0,16,  0,0,0,0,0,0,          0,'h104,2,1,0,'h200});
        vecs.push_back(vec_t'{0,1,3,1,'h300,  0,0,0,0,            16,16, 0,0,0,0,0,0,          0,'h104,2,1,0,'h200});
        vecs.push_back(vec_t'{0,0,0,0,0,      1,0,9,'h300,        0,16,  1,0,1,9,0,0,          0,'h104,2,1,0,'h200});
        vecs.push_back(vec_t'{0,0,0,0,0,      0,0,0,0,            0,16,  1,0,1,9,0,0,          1,9,0,3,0,'h200});
        vecs.push_back(vec_t'{0,1,4,0,0,      0,0,0,0,            16,16, 1,0,0,0,0,0,          0,9,0,3,0,'h200});
        vecs.push_back(vec_t'{0,1,4,0,0,      0,0,0,0,            16,16, 2,0,0,0,0,0,          0,9,0,3,0,'h200});
        vecs.push_back(vec_t'{0,1,4,0,0,      0,0,0,0,            16,16, 3,0,0,0,0,0,          0,9,0,3,0,'h200});
        vecs.push_back(vec_t'{0,0,0,0,0,      1,3,7,0,            3,2,   4,0,1,7,0,0,          0,9,0,3,0,'h200});
        vecs.push_back(vec_t'{0,0,0,0,0,      0,0,0,0,            3,2,   4,0,1,7,0,0,          0,9,0,3,0,'h200});
        vecs.push_back(vec_t'{0,0,0,0,0,      1,16,'h77,0,        1,16,  4,0,0,0,0,0,          0,9,0,3,0,'h200});
        vecs.push_back(vec_t'{0,0,0,0,0,      0,0,0,0,            1,16,  4,0,0,0,0,0,          0,9,0,3,0,'h200});

        idle();
        tick();

        for (int i = 0; i < vecs.size(); i++) begin
            rst                   = vecs[i].rst[0];
            enable_sign_from_cmd  = vecs[i].en[0];
            rd_from_cmd           = vecs[i].rd[4:0];
            is_jump_from_cmd      = vecs[i].jmp[0];
            predicted_pc_from_cmd = vecs[i].pred;
            valid_from_cdb        = vecs[i].cv[0];
            rob_id_from_cdb       = vecs[i].cid[4:0];
            V_from_cdb            = vecs[i].cval;
            real_pc_from_cdb      = vecs[i].crpc;
            query_id1_from_cmd    = vecs[i].q1[4:0];
            query_id2_from_cmd    = vecs[i].q2[4:0];
            #1;
            if (vecs[i].rst[0] == 1'b0) begin
                check($sformatf("row%0d tail", i), 32'(rob_id_to_cmd), vecs[i].e_tail);
                check($sformatf("row%0d full", i), 32'(full_to_cmd), vecs[i].e_full);
                check($sformatf("row%0d qready1", i), 32'(query_ready1_to_cmd), vecs[i].e_qr1);
                if (vecs[i].e_qr1[0]) check($sformatf("row%0d qV1", i), query_V1_to_cmd, vecs[i].e_qv1);
                check($sformatf("row%0d qready2", i), 32'(query_ready2_to_cmd), vecs[i].e_qr2);
                if (vecs[i].e_qr2[0]) check($sformatf("row%0d qV2", i), query_V2_to_cmd, vecs[i].e_qv2);
            end
            @(posedge clk);
            #1;
            check($sformatf("row%0d commit", i), 32'(commit_sign_to_reg), vecs[i].e_cm);
            check($sformatf("row%0d V_to_reg", i), V_to_reg, vecs[i].e_v);
            check($sformatf("row%0d Q_to_reg", i), 32'(Q_to_reg), vecs[i].e_q);
            check($sformatf("row%0d rd_to_reg", i), 32'(rd_to_reg), vecs[i].e_rd);
            check($sformatf("row%0d rollback", i), 32'(rollback_sign), vecs[i].e_rb);
            check($sformatf("row%0d rollback_pc", i), rollback_pc_to_if, vecs[i].e_pc);
        end

        // Fill all 16 entries, reject a 17th, then free one and wrap the tail.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            idle();
            enable_sign_from_cmd = 1'b1;
            rd_from_cmd = 5'(i);
            #1;
            check($sformatf("fill%0d tail", i), 32'(rob_id_to_cmd), 32'(i));
            check($sformatf("fill%0d full", i), 32'(full_to_cmd), 0);
            tick();
        end
        idle();
        #1;
        check("full_after_16", 32'(full_to_cmd), 1);
        check("tail_wrapped", 32'(rob_id_to_cmd), 0);
        enable_sign_from_cmd = 1'b1;
        rd_from_cmd = 5'd31;
        tick();
        idle();
        check("enable_while_full_tail", 32'(rob_id_to_cmd), 0);
        check("enable_while_full_full", 32'(full_to_cmd), 1);
        valid_from_cdb = 1'b1;
        rob_id_from_cdb = 5'd0;
        V_from_cdb = 32'hAA;
        tick();
        idle();
        check("fill_no_early_commit", 32'(commit_sign_to_reg), 0);
        tick();
        check("fill_commit", 32'(commit_sign_to_reg), 1);
        check("fill_commit_Q", 32'(Q_to_reg), 0);
        check("fill_commit_V", V_to_reg, 32'hAA);
        check("fill_commit_rd", 32'(rd_to_reg), 0);
        check("full_after_commit", 32'(full_to_cmd), 0);
        enable_sign_from_cmd = 1'b1;
        rd_from_cmd = 5'd2;
        #1;
        check("wrap_alloc_id", 32'(rob_id_to_cmd), 0);
        tick();
        idle();
        check("full_again", 32'(full_to_cmd), 1);
        check("wrap_no_commit", 32'(commit_sign_to_reg), 0);

        // Reset while the head is ready and an allocation is pending.
        do_reset();
        enable_sign_from_cmd = 1'b1;
        rd_from_cmd = 5'd6;
        tick();
        idle();
        valid_from_cdb = 1'b1;
        rob_id_from_cdb = 5'd0;
        V_from_cdb = 32'h66;
        tick();
        idle();
        rst = 1'b1;
        enable_sign_from_cmd = 1'b1;
        rd_from_cmd = 5'd9;
        tick();
        check("rst_mid_commit", 32'(commit_sign_to_reg), 0);
        check("rst_mid_rollback", 32'(rollback_sign), 0);
        check("rst_mid_V", V_to_reg, 0);
        check("rst_mid_Q", 32'(Q_to_reg), 16);
        check("rst_mid_rd", 32'(rd_to_reg), 0);
        check("rst_mid_pc", rollback_pc_to_if, 0);
        idle();
        query_id1_from_cmd = 5'd0;
        #1;
        check("rst_mid_tail", 32'(rob_id_to_cmd), 0);
        check("rst_mid_full", 32'(full_to_cmd), 0);
        check("rst_mid_query", 32'(query_ready1_to_cmd), 0);
        @(posedge clk);
        #1;
        check("rst_mid_no_late_commit", 32'(commit_sign_to_reg), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
